multicycle_main_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath.
- Decodes the 6-bit instruction opcode over successive cycles and drives every datapath enable and mux select.
- Produces the 2-bit aluOp consumed by alu_control: 00 add, 01 subtract, 10 decode by funct.
- Sits between the instruction register and the datapath, with a ready handshake to the unified memory.

---
 rtl/multicycle_main_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
//   Main control FSM for the multicycle MIPS datapath. Walks each instruction
//   through fetch/decode/execute/memory/write-back and drives every datapath
//   enable and mux select.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   opcode       instr[31:26] from the instruction register
//   mem_ready    unified memory completes the current read/write this cycle
//   pcWrite      unconditional PC load
//   pcWriteCond  PC load if ALU zero
//   iorD         memory address select: 0 = PC, 1 = ALUOut
//   memRead      memory read request
//   memWrite     memory write request
//   irWrite      instruction register load
//   memToReg     write-back source: 1 = MDR
//   regDst       destination register: 1 = rd, 0 = rt
//   regWrite     register file write
//   aluSrcA      ALU A input: 0 = PC, 1 = regA
//   aluSrcB      ALU B input: 00 regB, 01 4, 10 sign-ext imm, 11 imm<<2
//   aluOp        to alu_control: 00 add, 01 subtract, 10 decode by funct
//   pcSource     PC source: 00 = ALU result, 01 = ALUOut
//   illegal_op   one-cycle pulse in DECODE on an unrecognised opcode
//   state        current state, for debug
// -----------------------------------------------------------------------------
module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Decoded controls before the reset gating of the state-changing strobes.
  logic pc_write_raw;
  logic pc_write_cond_raw;
  logic mem_write_raw;
  logic ir_write_raw;
  logic reg_write_raw;
  logic illegal_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next        = FETCH;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    illegal_raw       = 1'b0;
    iorD              = 1'b0;
    memRead           = 1'b0;
    memToReg          = 1'b0;
    regDst            = 1'b0;
    aluSrcA           = 1'b0;
    aluSrcB           = 2'b00;
    aluOp             = 2'b00;
    pcSource          = 2'b00;

    case (state_reg)
      FETCH: begin
        memRead      = 1'b1;
        aluSrcB      = 2'b01;
        // IR and PC load only on the cycle the read actually completes,
        // so a stalled fetch never advances the PC.
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        state_next   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target precompute: PC+4 + (imm<<2) into ALUOut.
        aluSrcB = 2'b11;
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_next = MEMADDR;
        end else if (opcode == OP_RTYPE) begin
          state_next = EXEC;
        end else if (opcode == OP_BEQ) begin
          state_next = BRANCH;
        end else if (opcode == OP_ADDI) begin
          state_next = ADDIEX;
        end else begin
          illegal_raw = 1'b1;
          state_next  = FETCH;
        end
      end
      MEMADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
        if (opcode == OP_LW) begin
          state_next = MEMRD;
        end else if (opcode == OP_SW) begin
          state_next = MEMWR;
        end else begin
          // Opcode is not expected to change here; recover to a clean fetch.
          state_next = FETCH;
        end
      end
      MEMRD: begin
        memRead    = 1'b1;
        iorD       = 1'b1;
        state_next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        reg_write_raw = 1'b1;
        memToReg      = 1'b1;
        state_next    = FETCH;
      end
      MEMWR: begin
        // Request and address held steady for every wait cycle.
        mem_write_raw = 1'b1;
        iorD          = 1'b1;
        state_next    = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        aluSrcA    = 1'b1;
        aluOp      = 2'b10;
        state_next = RWB;
      end
      RWB: begin
        reg_write_raw = 1'b1;
        regDst        = 1'b1;
        state_next    = FETCH;
      end
      BRANCH: begin
        aluSrcA           = 1'b1;
        aluOp             = 2'b01;
        pc_write_cond_raw = 1'b1;
        pcSource          = 2'b01;
        state_next        = FETCH;
      end
      ADDIEX: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'b10;
        state_next = ADDIWB;
      end
      ADDIWB: begin
        reg_write_raw = 1'b1;
        state_next    = FETCH;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Reset wins over anything in flight: no architectural state may change
  // while it is held, including a store that was still waiting on memory.
  assign pcWrite     = pc_write_raw      & ~reset;
  assign pcWriteCond = pc_write_cond_raw & ~reset;
  assign memWrite    = mem_write_raw     & ~reset;
  assign irWrite     = ir_write_raw      & ~reset;
  assign regWrite    = reg_write_raw     & ~reset;
  assign illegal_op  = illegal_raw       & ~reset;

  assign state = state_reg;

endmodule

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control
//   Directed bench for multicycle_main_control. Each cycle the expected state
//   and control word are pushed to a scoreboard queue when inputs are driven,
//   then popped and compared against the DUT mid-cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_main_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegal_op;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      ctrl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, illegal_op;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;
  exp_t sb_q[$];

  multicycle_main_control dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .iorD        (iorD),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .irWrite     (irWrite),
    .memToReg    (memToReg),
    .regDst      (regDst),
    .regWrite    (regWrite),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .pcSource    (pcSource),
    .illegal_op  (illegal_op),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Control word required in a given state, written from the state table.
  function automatic ctrl_t want(input logic [3:0] st, input logic [5:0] op,
                                 input logic mr, input logic rst);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0: begin
        c.memRead = 1'b1; c.aluSrcB = 2'b01;
        c.irWrite = mr & ~rst; c.pcWrite = mr & ~rst;
      end
      4'd1: begin
        c.aluSrcB = 2'b11;
        c.illegal_op = ~rst & !(op == OP_RTYPE || op == OP_LW || op == OP_SW ||
                                op == OP_BEQ || op == OP_ADDI);
      end
      4'd2:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      4'd3:  begin c.memRead = 1'b1; c.iorD = 1'b1; end
      4'd4:  begin c.regWrite = ~rst; c.memToReg = 1'b1; end
      4'd5:  begin c.memWrite = ~rst; c.iorD = 1'b1; end
      4'd6:  begin c.aluSrcA = 1'b1; c.aluOp = 2'b10; end
      4'd7:  begin c.regWrite = ~rst; c.regDst = 1'b1; end
      4'd8:  begin
        c.aluSrcA = 1'b1; c.aluOp = 2'b01;
        c.pcWriteCond = ~rst; c.pcSource = 2'b01;
      end
      4'd9:  begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
      4'd10: begin c.regWrite = ~rst; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle: drive inputs, push expectation, compare mid-cycle.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr,
                     input logic [3:0] exp_st, input string tag);
    exp_t e;
    ctrl_t act;
    @(negedge clk);
    reset = rst;
    opcode = op;
    mem_ready = mr;
    e.st = exp_st;
    e.ctrl = want(exp_st, op, mr, rst);
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    act = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
           regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegal_op};

    vectors++;
    assert (state === e.st) else begin
      miscompares++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, e.st);
    end
    vectors++;
    assert (act === e.ctrl) else begin
      miscompares++;
      $error("FAIL %s ctrl: observed %b expected %b", tag, act, e.ctrl);
    end
    vectors++;
    assert (aluOp !== 2'b11) else begin
      miscompares++;
      $error("FAIL %s aluOp11: observed %b expected not 11", tag, aluOp);
    end
    $display("cyc %-10s rst=%0d op=%b mr=%0d state=%0d ctrl=%b", tag, rst, op,
             mr, state, act);
  endtask

  initial begin
    reset = 1'b1;
    opcode = OP_SW;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state while still held.
    cyc(1'b1, OP_SW, 1'b1, 4'd0, "rst_hold");

    // Get into MEMWR with memory stalled, then reset for two cycles.
    cyc(1'b0, OP_SW, 1'b1, 4'd0, "sw_fetch");
    cyc(1'b0, OP_SW, 1'b1, 4'd1, "sw_dec");
    cyc(1'b0, OP_SW, 1'b1, 4'd2, "sw_addr");
    cyc(1'b0, OP_SW, 1'b0, 4'd5, "sw_wr_w0");
    cyc(1'b0, OP_SW, 1'b0, 4'd5, "sw_wr_w1");
    cyc(1'b1, OP_SW, 1'b0, 4'd5, "rst_mwr");
    cyc(1'b1, OP_SW, 1'b0, 4'd0, "rst_fetch");

    // R-type: 0,1,6,7
    cyc(1'b0, OP_RTYPE, 1'b1, 4'd0, "r_fetch");
    cyc(1'b0, OP_RTYPE, 1'b1, 4'd1, "r_dec");
    cyc(1'b0, OP_RTYPE, 1'b1, 4'd6, "r_exec");
    cyc(1'b0, OP_RTYPE, 1'b1, 4'd7, "r_wb");

    // LW with two MEMRD wait cycles; opcode garbage in MEMRD is ignored.
    cyc(1'b0, OP_LW, 1'b1, 4'd0, "lw_fetch");
    cyc(1'b0, OP_LW, 1'b1, 4'd1, "lw_dec");
    cyc(1'b0, OP_LW, 1'b1, 4'd2, "lw_addr");
    cyc(1'b0, OP_SW, 1'b0, 4'd3, "lw_rd_w0");
    cyc(1'b0, OP_BAD, 1'b0, 4'd3, "lw_rd_w1");
    cyc(1'b0, OP_LW, 1'b1, 4'd3, "lw_rd");
    cyc(1'b0, OP_LW, 1'b1, 4'd4, "lw_wb");

    // BEQ: 0,1,8; opcode change in BRANCH has no effect.
    cyc(1'b0, OP_BEQ, 1'b1, 4'd0, "beq_fetch");
    cyc(1'b0, OP_BEQ, 1'b1, 4'd1, "beq_dec");
    cyc(1'b0, OP_BAD, 1'b1, 4'd8, "beq_br");

    // SW then ADDI back-to-back.
    cyc(1'b0, OP_SW, 1'b1, 4'd0, "sw2_fetch");
    cyc(1'b0, OP_SW, 1'b1, 4'd1, "sw2_dec");
    cyc(1'b0, OP_SW, 1'b1, 4'd2, "sw2_addr");
    cyc(1'b0, OP_SW, 1'b1, 4'd5, "sw2_wr");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd0, "ad_fetch");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd1, "ad_dec");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd9, "ad_ex");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd10, "ad_wb");

    // Illegal opcode: 0,1,0 with a one-cycle illegal_op pulse.
    cyc(1'b0, OP_BAD, 1'b1, 4'd0, "ill_fetch");
    cyc(1'b0, OP_BAD, 1'b1, 4'd1, "ill_dec");

    // Fetch stalled three cycles, then an ADDI completes.
    cyc(1'b0, OP_ADDI, 1'b0, 4'd0, "fst_w0");
    cyc(1'b0, OP_ADDI, 1'b0, 4'd0, "fst_w1");
    cyc(1'b0, OP_ADDI, 1'b0, 4'd0, "fst_w2");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd0, "fst_go");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd1, "fst_dec");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd9, "fst_ex");
    cyc(1'b0, OP_ADDI, 1'b1, 4'd10, "fst_wb");
    cyc(1'b0, OP_RTYPE, 1'b0, 4'd0, "end_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
